zverif_umi_top: RTL and testbench
=================================

# zverif_umi_top

Top-level verification target with a 256-bit UMI packet endpoint in front of a small word-addressed memory. It accepts UMI write and read-request packets on its RX port and returns read-response packets on its TX port. It also drives a sticky trap flag and an optional transaction trace stream. It sits directly under the simulation harness, which bridges the UMI ports to an external host over a message queue.

## Interface
Parameters:
- DEPTH, 1024: memory size in 32-bit words (power of two).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- trap  out  1  sticky error flag.
- trace_valid  out  1  one-cycle pulse per accepted packet.
- trace_data  out  36  {opcode[3:0], dstaddr[31:0]} of the accepted packet.
- umi_packet_rx  in  256  incoming packet.
- umi_valid_rx  in  1  RX packet valid.
- umi_ready_rx  out  1  RX ready.
- umi_packet_tx  out  256  outgoing response packet.
- umi_valid_tx  out  1  TX packet valid.
- umi_ready_tx  in  1  TX ready.

## Operation
- Packet fields: [7:0] opcode, [31:8] reserved, [63:32] dstaddr, [127:64] srcaddr (return address; only [95:64] used), [159:128] write data, [255:160] ignored.
- Opcode 0x01 WRITE: stores the write data at word index dstaddr[log2(DEPTH)+1:2].
- Opcode 0x02 READ: captures the addressed word into a single response register and raises umi_valid_tx.
- Response packet layout:
  - [7:0] = 0x03, [31:8] = 0.
  - [63:32] = request srcaddr[31:0].
  - [95:64] = request dstaddr, [127:96] = 0.
  - [159:128] = read data, [255:160] = 0.
- Error conditions: any other opcode, dstaddr >= 4*DEPTH, or dstaddr[1:0] != 0. On error the packet is consumed and discarded, memory is unchanged, no response is generated, and trap is set. trap stays set until rst.
- Packets continue to be accepted after trap is set. Valid packets keep executing normally.
- Memory contents are not reset. A read of a never-written word returns undefined data.

## Timing
- RX transfer occurs on a rising edge where umi_valid_rx && umi_ready_rx.
- umi_ready_rx = !rst && !umi_valid_tx (combinational). No new packet is accepted while a response is pending, so RX acceptance and TX completion never coincide.
- WRITE: memory is updated at the accepting edge. A read accepted on the next cycle returns the new data.
- READ latency: accepted at edge N → umi_valid_tx high and umi_packet_tx valid from edge N onward (visible in cycle N+1).
- TX transfer occurs on the first rising edge with umi_valid_tx && umi_ready_tx. umi_valid_tx clears at that edge.
- umi_packet_tx is held stable while umi_valid_tx is high. umi_ready_tx arriving late (any number of cycles) is legal. umi_ready_tx while umi_valid_tx is low is ignored.
- trace_valid pulses for exactly the cycle after each accepting edge, errored packets included. trace_data holds the last value otherwise.
- Reset values: trap 0, trace_valid 0, trace_data 0, umi_valid_tx 0, umi_packet_tx 0, umi_ready_rx 0 during reset and 1 after release.
- Reset asserted mid-response drops the pending response. The host must reissue the read.

## Configuration
- ZVERIF_TRACE_EN defined: trace_valid and trace_data behave as above.
- ZVERIF_TRACE_EN undefined: trace_valid and trace_data are constant 0, and the trace registers are not built. UMI and trap behaviour are identical in both builds.

## Test plan
- WRITE dstaddr 0x10 data 0xDEADBEEF, then READ dstaddr 0x10 srcaddr 0x2000 → response opcode 0x03, [63:32]=0x2000, [95:64]=0x10, [159:128]=0xDEADBEEF.
- READ with umi_ready_tx held low 50 cycles → umi_valid_tx and packet stable, umi_ready_rx low throughout. Ready pulse → valid drops next edge, umi_ready_rx returns to 1.
- Opcode 0x07 → packet consumed, no TX, trap=1. A following valid write/read still works and trap remains 1.
- dstaddr 0x1000 (DEPTH=1024) and dstaddr 0x12 → trap=1, memory unchanged, no response.
- Reset asserted while a response is pending → umi_valid_tx=0, trap=0, umi_packet_tx=0. Memory data written before reset is still readable afterwards.
- ZVERIF_TRACE_EN build: WRITE to 0x40 → trace_valid single pulse, trace_data=0x1_00000040. Build without the macro: trace outputs stay 0.

Source files
------------

// File: rtl/zverif_umi_top.sv
`default_nettype none
//==============================================================================
// Module   : zverif_umi_top
// Purpose  : 256-bit UMI packet endpoint in front of a word-addressed memory.
//            Accepts WRITE (0x01) and READ (0x02) request packets on RX and
//            returns read-response packets (0x03) on TX through a single
//            response register. Malformed requests set a sticky trap flag.
//            An optional trace stream reports every accepted packet.
// Config   : ZVERIF_TRACE_EN - when defined, builds the trace registers;
//            otherwise trace_valid/trace_data are tied to 0.
// Ports    : clk, rst (async, active-high)
//            trap                 sticky error flag
//            trace_valid/_data    per-packet trace {opcode[3:0], dstaddr}
//            umi_packet_rx/valid_rx/ready_rx   request channel
//            umi_packet_tx/valid_tx/ready_tx   response channel
// Revision : 1.0 - initial release
//==============================================================================
module zverif_umi_top #(
   parameter int DEPTH = 1024
) (
   input  logic         clk,
   input  logic         rst,
   output logic         trap,
   output logic         trace_valid,
   output logic [35:0]  trace_data,
   input  logic [255:0] umi_packet_rx,
   input  logic         umi_valid_rx,
   output logic         umi_ready_rx,
   output logic [255:0] umi_packet_tx,
   output logic         umi_valid_tx,
   input  logic         umi_ready_tx
);

   localparam int          ADDR_W      = $clog2(DEPTH);
   localparam logic [31:0] ADDR_LIMIT  = 32'(4 * DEPTH);
   localparam logic [7:0]  OP_WRITE    = 8'h01;
   localparam logic [7:0]  OP_READ     = 8'h02;
   localparam logic [7:0]  OP_RESPONSE = 8'h03;

   // Request field extraction
   logic [7:0]        opcode;
   logic [31:0]       dstaddr;
   logic [31:0]       srcaddr;
   logic [31:0]       wdata;
   logic [ADDR_W-1:0] word_idx;

   assign opcode   = umi_packet_rx[7:0];
   assign dstaddr  = umi_packet_rx[63:32];
   assign srcaddr  = umi_packet_rx[95:64];
   assign wdata    = umi_packet_rx[159:128];
   assign word_idx = dstaddr[ADDR_W+1:2];

   // Reserved/ignored request bits are intentionally not consumed.
   logic unused_rx;
   assign unused_rx = ^{umi_packet_rx[255:160], umi_packet_rx[127:96], umi_packet_rx[31:8]};

   logic         valid_tx_q, valid_tx_d;
   logic [255:0] packet_tx_q, packet_tx_d;
   logic         trap_q, trap_d;

   logic accept;
   logic addr_ok;
   logic do_write;
   logic do_read;
   logic is_error;

   // Back-pressure while a response is pending keeps RX acceptance and TX
   // completion from ever landing on the same edge.
   assign umi_ready_rx = !rst && !valid_tx_q;
   assign accept       = umi_valid_rx && umi_ready_rx;
   assign addr_ok      = (dstaddr < ADDR_LIMIT) && (dstaddr[1:0] == 2'b00);
   assign do_write     = accept && addr_ok && (opcode == OP_WRITE);
   assign do_read      = accept && addr_ok && (opcode == OP_READ);
   assign is_error     = accept && !do_write && !do_read;

   // Memory: deliberately not reset so contents survive rst.
   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (do_write) begin
         mem[word_idx] <= wdata;
      end
   end

   always_comb begin
      valid_tx_d  = valid_tx_q;
      packet_tx_d = packet_tx_q;
      trap_d      = trap_q | is_error;
      if (do_read) begin
         valid_tx_d  = 1'b1;
         packet_tx_d = {96'b0, mem[word_idx], 32'b0, dstaddr, srcaddr, 24'b0, OP_RESPONSE};
      end else if (valid_tx_q && umi_ready_tx) begin
         valid_tx_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_tx_q  <= 1'b0;
         packet_tx_q <= '0;
         trap_q      <= 1'b0;
      end else begin
         valid_tx_q  <= valid_tx_d;
         packet_tx_q <= packet_tx_d;
         trap_q      <= trap_d;
      end
   end

   assign umi_valid_tx  = valid_tx_q;
   assign umi_packet_tx = packet_tx_q;
   assign trap          = trap_q;

`ifdef ZVERIF_TRACE_EN
   logic        trace_valid_q, trace_valid_d;
   logic [35:0] trace_data_q, trace_data_d;

   always_comb begin
      trace_valid_d = accept;
      trace_data_d  = trace_data_q;
      if (accept) begin
         trace_data_d = {opcode[3:0], dstaddr};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trace_valid_q <= 1'b0;
         trace_data_q  <= '0;
      end else begin
         trace_valid_q <= trace_valid_d;
         trace_data_q  <= trace_data_d;
      end
   end

   assign trace_valid = trace_valid_q;
   assign trace_data  = trace_data_q;
`else
   assign trace_valid = 1'b0;
   assign trace_data  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_zverif_umi_top.sv
`default_nettype none
//==============================================================================
// Module   : tb_zverif_umi_top
// Purpose  : Directed self-checking bench for zverif_umi_top. Trace
//            expectations follow ZVERIF_TRACE_EN.
// Revision : 1.0 - initial release
//==============================================================================
module tb_zverif_umi_top;

`ifdef ZVERIF_TRACE_EN
   localparam bit TRACE_ON = 1'b1;
`else
   localparam bit TRACE_ON = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic         trap;
   logic         trace_valid;
   logic [35:0]  trace_data;
   logic [255:0] umi_packet_rx;
   logic         umi_valid_rx;
   logic         umi_ready_rx;
   logic [255:0] umi_packet_tx;
   logic         umi_valid_tx;
   logic         umi_ready_tx;

   int n_checks = 0;
   int n_errors = 0;

   zverif_umi_top #(.DEPTH(1024)) dut (
      .clk           (clk),
      .rst           (rst),
      .trap          (trap),
      .trace_valid   (trace_valid),
      .trace_data    (trace_data),
      .umi_packet_rx (umi_packet_rx),
      .umi_valid_rx  (umi_valid_rx),
      .umi_ready_rx  (umi_ready_rx),
      .umi_packet_tx (umi_packet_tx),
      .umi_valid_tx  (umi_valid_tx),
      .umi_ready_tx  (umi_ready_tx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] req(input logic [7:0] op, input logic [31:0] dst,
                                        input logic [31:0] src, input logic [31:0] data);
      return {96'b0, data, 32'b0, src, dst, 24'b0, op};
   endfunction

   function automatic logic [255:0] resp(input logic [31:0] src, input logic [31:0] dst,
                                         input logic [31:0] data);
      return {96'b0, data, 32'b0, dst, src, 24'b0, 8'h03};
   endfunction

   // Presents one packet and returns #1 after its accepting edge.
   task automatic send(input logic [7:0] op, input logic [31:0] dst,
                       input logic [31:0] src, input logic [31:0] data);
      int n;
      @(negedge clk);
      umi_packet_rx = req(op, dst, src, data);
      umi_valid_rx  = 1'b1;
      n = 0;
      while (!umi_ready_rx && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("rx_ready_timeout", 256'(umi_ready_rx), 256'(1));
      @(posedge clk);
      #1;
      umi_valid_rx  = 1'b0;
      umi_packet_rx = '0;
   endtask

   // Pulses umi_ready_tx for one edge and checks the handshake completes.
   task automatic drain(input string tag);
      umi_ready_tx = 1'b1;
      @(posedge clk);
      #1;
      umi_ready_tx = 1'b0;
      check({tag, "_valid_drop"}, 256'(umi_valid_tx), 256'(0));
      check({tag, "_ready_rx"},   256'(umi_ready_rx), 256'(1));
   endtask

   task automatic read_expect(input string tag, input logic [31:0] dst,
                              input logic [31:0] src, input logic [31:0] data);
      send(8'h02, dst, src, data);
      check({tag, "_valid"},  256'(umi_valid_tx), 256'(1));
      check({tag, "_packet"}, umi_packet_tx, resp(src, dst, data));
      drain(tag);
   endtask

   initial begin
      rst           = 1'b1;
      umi_packet_rx = '0;
      umi_valid_rx  = 1'b0;
      umi_ready_tx  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_trap",        256'(trap),         256'(0));
      check("rst_valid_tx",    256'(umi_valid_tx), 256'(0));
      check("rst_packet_tx",   umi_packet_tx,      256'(0));
      check("rst_ready_rx",    256'(umi_ready_rx), 256'(0));
      check("rst_trace_valid", 256'(trace_valid),  256'(0));
      check("rst_trace_data",  256'(trace_data),   256'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_rst_ready_rx", 256'(umi_ready_rx), 256'(1));

      // Basic write then read-back
      send(8'h01, 32'h10, 32'h0, 32'hDEADBEEF);
      check("wr_no_tx",      256'(umi_valid_tx), 256'(0));
      check("wr_trace_vld",  256'(trace_valid),  256'(TRACE_ON ? 1 : 0));
      check("wr_trace_data", 256'(trace_data),   TRACE_ON ? 256'(36'h0_00000010 | 36'h1_00000000) : 256'(0));
      read_expect("rd_10", 32'h10, 32'h2000, 32'hDEADBEEF);

      // Long back-pressure on TX
      send(8'h01, 32'h20, 32'h0, 32'h12345678);
      send(8'h02, 32'h20, 32'hCAFE0000, 32'h0);
      for (int i = 0; i < 50; i++) begin
         check("bp_valid",    256'(umi_valid_tx), 256'(1));
         check("bp_packet",   umi_packet_tx,      resp(32'hCAFE0000, 32'h20, 32'h12345678));
         check("bp_ready_rx", 256'(umi_ready_rx), 256'(0));
         @(posedge clk);
         #1;
      end
      drain("bp");

      // Trace contents for a write to 0x40, then the pulse ends
      send(8'h01, 32'h40, 32'h0, 32'h0BADF00D);
      check("tr40_vld",  256'(trace_valid), 256'(TRACE_ON ? 1 : 0));
      check("tr40_data", 256'(trace_data),  TRACE_ON ? 256'(36'h1_00000040) : 256'(0));
      @(posedge clk);
      #1;
      check("tr40_pulse_end", 256'(trace_valid), 256'(0));
      check("tr40_data_hold", 256'(trace_data),  TRACE_ON ? 256'(36'h1_00000040) : 256'(0));

      // Bad opcode: consumed, no TX, trap sticky; later traffic still works
      send(8'h07, 32'h10, 32'h0, 32'h11111111);
      check("badop_no_tx",  256'(umi_valid_tx), 256'(0));
      check("badop_trap",   256'(trap),         256'(1));
      check("badop_trace",  256'(trace_valid),  256'(TRACE_ON ? 1 : 0));
      check("badop_tdata",  256'(trace_data),   TRACE_ON ? 256'(36'h7_00000010) : 256'(0));
      read_expect("rd_after_badop", 32'h10, 32'h3000, 32'hDEADBEEF);
      check("trap_sticky", 256'(trap), 256'(1));

      // Out-of-range and misaligned writes leave memory untouched
      send(8'h01, 32'h0, 32'h0, 32'hA5A5A5A5);
      send(8'h01, 32'h1000, 32'h0, 32'h99999999);
      check("oor_no_tx", 256'(umi_valid_tx), 256'(0));
      send(8'h01, 32'h12, 32'h0, 32'h55555555);
      check("mis_no_tx", 256'(umi_valid_tx), 256'(0));
      read_expect("rd_0_after_oor", 32'h0,  32'h4000, 32'hA5A5A5A5);
      read_expect("rd_10_after_mis", 32'h10, 32'h4004, 32'hDEADBEEF);
      send(8'h02, 32'h1000, 32'h0, 32'h0);
      check("oor_rd_no_tx", 256'(umi_valid_tx), 256'(0));
      send(8'h02, 32'h0FFC, 32'h0, 32'h0);
      check("last_word_rd_valid", 256'(umi_valid_tx), 256'(1));
      drain("last_word");
      check("trap_still_set", 256'(trap), 256'(1));

      // Reset while a response is pending
      send(8'h02, 32'h40, 32'h5000, 32'h0);
      check("pend_valid", 256'(umi_valid_tx), 256'(1));
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_valid_tx", 256'(umi_valid_tx), 256'(0));
      check("midrst_packet",   umi_packet_tx,      256'(0));
      check("midrst_trap",     256'(trap),         256'(0));
      check("midrst_ready_rx", 256'(umi_ready_rx), 256'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("postrst2_ready_rx", 256'(umi_ready_rx), 256'(1));
      read_expect("rd_after_rst", 32'h10, 32'h6000, 32'hDEADBEEF);
      read_expect("rd40_after_rst", 32'h40, 32'h6004, 32'h0BADF00D);
      check("trap_clear_after_rst", 256'(trap), 256'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
